// File: rtl/eq_pkg.sv
// Shared types, default coefficients and saturation helper for the adaptive equalizer.
package eq_pkg;

  typedef enum logic [1:0] {IDLE, TRAIN, HOLD} eq_state_e;

  localparam int MAX_TAPS = 8;

  // Default feed-forward taps; entries beyond the listed ones are zero.
  function automatic real b_default(input int idx);
    case (idx)
      0:       return 2.003;
      1:       return -1.409;
      default: return 0.0;
    endcase
  endfunction

  function automatic real a_default(input int idx);
    case (idx)
      0:       return 0.4421;
      1:       return -0.03657;
      default: return 0.0;
    endcase
  endfunction

  function automatic real sat_real(input real x, input real lim);
    if (x > lim)  return lim;
    if (x < -lim) return -lim;
    return x;
  endfunction

endpackage

// File: rtl/eq_coef_bank.sv
// Coefficient storage for the equalizer: write port, sign-sign LMS on the
// feedback taps, and saturation of every stored value.
module eq_coef_bank
  import eq_pkg::*;
#(
  parameter int  NUM_FF   = 3,
  parameter int  NUM_FB   = 2,
  parameter real MU       = 0.01,
  parameter real COEF_MAX = 4.0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic              wr_fb,
  input  logic [2:0]        wr_idx,
  input  real               wr_data,
  input  logic              adapt,
  input  logic signed [1:0] err_sgn,
  input  logic [NUM_FB-1:0] dec_taps,
  output real               b_coef [NUM_FF],
  output real               a_coef [NUM_FB]
);

  real b_q [NUM_FF];
  real b_d [NUM_FF];
  real a_q [NUM_FB];
  real a_d [NUM_FB];

  always_comb begin
    for (int k = 0; k < NUM_FF; k++) b_d[k] = b_q[k];
    for (int k = 0; k < NUM_FB; k++) a_d[k] = a_q[k];

    // Decision history is 0/1, so sgn(d - 0.5) is always +1 or -1.
    if (adapt) begin
      for (int k = 0; k < NUM_FB; k++)
        a_d[k] = sat_real(a_q[k] - MU * real'(err_sgn) * (dec_taps[k] ? 1.0 : -1.0),
                          COEF_MAX);
    end

    if (wr_en) begin
      for (int k = 0; k < NUM_FF; k++)
        if (!wr_fb && (int'(wr_idx) == k)) b_d[k] = sat_real(wr_data, COEF_MAX);
      for (int k = 0; k < NUM_FB; k++)
        if (wr_fb && (int'(wr_idx) == k)) a_d[k] = sat_real(wr_data, COEF_MAX);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NUM_FF; k++) b_q[k] <= b_default(k);
      for (int k = 0; k < NUM_FB; k++) a_q[k] <= a_default(k);
    end else begin
      for (int k = 0; k < NUM_FF; k++) b_q[k] <= b_d[k];
      for (int k = 0; k < NUM_FB; k++) a_q[k] <= a_d[k];
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_FF; k++) b_coef[k] = b_q[k];
    for (int k = 0; k < NUM_FB; k++) a_coef[k] = a_q[k];
  end

endmodule

// File: rtl/adaptive_equalizer.sv
// Feed-forward plus decision-feedback equalizer with slicer and a sign-sign
// LMS training FSM that adapts the feedback taps.
module adaptive_equalizer
  import eq_pkg::*;
#(
  parameter int  NUM_FF    = 3,
  parameter int  NUM_FB    = 2,
  parameter real THRESHOLD = 0.49,
  parameter real MU        = 0.01,
  parameter real COEF_MAX  = 4.0,
  parameter int  TRAIN_LEN = 256
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  real        equalizer_in,
  input  logic       coef_wr,
  input  logic       coef_fb,
  input  logic [2:0] coef_idx,
  input  real        coef_data,
  output logic       coef_ready,
  input  logic       train_start,
  output logic       train_busy,
  output logic       train_done,
  output real        eq_analog,
  output real        err,
  output logic       equalizer_out
);

  localparam int CNT_W = (TRAIN_LEN > 1) ? $clog2(TRAIN_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TRAIN_LEN - 1);

  real u_q [NUM_FF];
  real u_d [NUM_FF];
  // dec_q[0] is the registered slicer output; dec_q[k] is that decision k edges old.
  logic [NUM_FB-1:0] dec_q, dec_d;
  real eq_analog_q, eq_analog_d;
  real err_q, err_d;
  eq_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  real b_coef [NUM_FF];
  real a_coef [NUM_FB];
  real y, e;
  logic slice;
  logic signed [1:0] err_sgn;
  logic adapt;

  // Filter sum and slicer on pre-edge register values
  always_comb begin
    y = 0.0;
    for (int k = 0; k < NUM_FF; k++) y = y + b_coef[k] * u_q[k];
    for (int k = 0; k < NUM_FB; k++) y = y + a_coef[k] * (dec_q[k] ? 1.0 : 0.0);
    slice   = (y > THRESHOLD);
    e       = y - (slice ? 1.0 : 0.0);
    err_sgn = (e > 0.0) ? 2'sd1 : ((e < 0.0) ? -2'sd1 : 2'sd0);
  end

  always_comb begin
    for (int k = 0; k < NUM_FF; k++) u_d[k] = u_q[k];
    dec_d       = dec_q;
    eq_analog_d = eq_analog_q;
    err_d       = err_q;
    if (en) begin
      u_d[0] = equalizer_in;
      for (int k = 1; k < NUM_FF; k++) u_d[k] = u_q[k-1];
      dec_d[0] = slice;
      for (int k = 1; k < NUM_FB; k++) dec_d[k] = dec_q[k-1];
      eq_analog_d = y;
      err_d       = e;
    end
  end

  // Training FSM; train_start is honoured regardless of en
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (train_start) begin
          state_d = TRAIN;
          cnt_d   = '0;
        end
      end
      TRAIN: begin
        if (train_start) begin
          cnt_d = '0;
        end else if (en) begin
          if (cnt_q == CNT_LAST) begin
            state_d = HOLD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      HOLD: begin
        if (train_start) begin
          state_d = TRAIN;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NUM_FF; k++) u_q[k] <= 0.0;
      dec_q       <= '0;
      eq_analog_q <= 0.0;
      err_q       <= 0.0;
      state_q     <= IDLE;
      cnt_q       <= '0;
    end else begin
      for (int k = 0; k < NUM_FF; k++) u_q[k] <= u_d[k];
      dec_q       <= dec_d;
      eq_analog_q <= eq_analog_d;
      err_q       <= err_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
    end
  end

  assign adapt = (state_q == TRAIN) && en;

  eq_coef_bank #(
    .NUM_FF   (NUM_FF),
    .NUM_FB   (NUM_FB),
    .MU       (MU),
    .COEF_MAX (COEF_MAX)
  ) u_coef_bank (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (coef_wr && coef_ready),
    .wr_fb    (coef_fb),
    .wr_idx   (coef_idx),
    .wr_data  (coef_data),
    .adapt    (adapt),
    .err_sgn  (err_sgn),
    .dec_taps (dec_q),
    .b_coef   (b_coef),
    .a_coef   (a_coef)
  );

  assign coef_ready    = (state_q != TRAIN);
  assign train_busy    = (state_q == TRAIN);
  assign train_done    = (state_q == HOLD);
  assign eq_analog     = eq_analog_q;
  assign err           = err_q;
  assign equalizer_out = dec_q[0];

endmodule

// File: tb/tb_adaptive_equalizer.sv
// Directed bench for adaptive_equalizer: a history-queue reference model checked
// every cycle, plus hand-computed literal expectations.
module tb_adaptive_equalizer;

  localparam int  NFF  = 3;
  localparam int  NFB  = 2;
  localparam int  TLEN = 16;
  localparam real TH   = 0.49;
  localparam real MU   = 0.01;
  localparam real CMAX = 4.0;
  localparam int  M_IDLE = 0, M_TRAIN = 1, M_HOLD = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b1;
  real        equalizer_in = 0.0;
  logic       coef_wr = 1'b0;
  logic       coef_fb = 1'b0;
  logic [2:0] coef_idx = 3'd0;
  real        coef_data = 0.0;
  logic       coef_ready;
  logic       train_start = 1'b0;
  logic       train_busy;
  logic       train_done;
  real        eq_analog;
  real        err;
  logic       equalizer_out;

  int n_checks = 0;
  int n_fail   = 0;

  adaptive_equalizer #(
    .NUM_FF(NFF), .NUM_FB(NFB), .THRESHOLD(TH), .MU(MU),
    .COEF_MAX(CMAX), .TRAIN_LEN(TLEN)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .equalizer_in(equalizer_in),
    .coef_wr(coef_wr), .coef_fb(coef_fb), .coef_idx(coef_idx), .coef_data(coef_data),
    .coef_ready(coef_ready), .train_start(train_start), .train_busy(train_busy),
    .train_done(train_done), .eq_analog(eq_analog), .err(err),
    .equalizer_out(equalizer_out)
  );

  always #5 clk = ~clk;

  task automatic chk_r(input string name, input real act, input real exp);
    real d;
    d = act - exp;
    if (d < 0.0) d = -d;
    n_checks++;
    if (!(d < 1e-9)) begin
      n_fail++;
      $display("FAIL %s: got %f, expected %f", name, act, exp);
    end
  endtask

  task automatic chk_b(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic chk_i(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic real clamp(input real x);
    if (x > CMAX) return CMAX;
    if (x < -CMAX) return -CMAX;
    return x;
  endfunction

  function automatic real sgn(input real x);
    if (x > 0.0) return 1.0;
    if (x < 0.0) return -1.0;
    return 0.0;
  endfunction

  // Reference model: full input/decision histories, newest first.
  real mb [NFF];
  real ma [NFB];
  real uq [$];
  bit  dq [$];
  int  mst, mcnt;
  real exp_analog, exp_err;
  bit  exp_out;
  real my, me;
  bit  ms;

  always @(posedge clk) begin
    if (reset) begin
      mb[0] = 2.003; mb[1] = -1.409; mb[2] = 0.0;
      ma[0] = 0.4421; ma[1] = -0.03657;
      uq.delete(); dq.delete();
      mst = M_IDLE; mcnt = 0;
      exp_analog = 0.0; exp_err = 0.0; exp_out = 1'b0;
    end else begin
      my = 0.0;
      for (int k = 0; k < NFF; k++) my = my + mb[k] * ((k < uq.size()) ? uq[k] : 0.0);
      for (int k = 0; k < NFB; k++) my = my + ma[k] * ((k < dq.size() && dq[k]) ? 1.0 : 0.0);
      ms = (my > TH);
      me = my - (ms ? 1.0 : 0.0);
      if (en) begin
        if (mst == M_TRAIN)
          for (int k = 0; k < NFB; k++)
            ma[k] = clamp(ma[k] - MU * sgn(me) * ((k < dq.size() && dq[k]) ? 1.0 : -1.0));
        uq.push_front(equalizer_in);
        dq.push_front(ms);
        if (uq.size() > 16) void'(uq.pop_back());
        if (dq.size() > 16) void'(dq.pop_back());
        exp_analog = my; exp_err = me; exp_out = ms;
      end
      if (coef_wr && mst != M_TRAIN) begin
        if (!coef_fb && int'(coef_idx) < NFF) mb[coef_idx] = clamp(coef_data);
        if (coef_fb && int'(coef_idx) < NFB) ma[coef_idx] = clamp(coef_data);
      end
      if (train_start) begin
        mst = M_TRAIN; mcnt = 0;
      end else if (mst == M_TRAIN && en) begin
        if (mcnt == TLEN - 1) mst = M_HOLD;
        else mcnt++;
      end
    end
    #1;
    chk_r("model_eq_analog", eq_analog, exp_analog);
    chk_r("model_err", err, exp_err);
    chk_b("model_equalizer_out", equalizer_out, exp_out);
    chk_b("model_train_busy", train_busy, mst == M_TRAIN);
    chk_b("model_train_done", train_done, mst == M_HOLD);
    chk_b("model_coef_ready", coef_ready, mst != M_TRAIN);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input bit fb, input int idx, input real v);
    coef_wr = 1'b1; coef_fb = fb; coef_idx = 3'(idx); coef_data = v;
    tick();
    coef_wr = 1'b0;
  endtask

  logic [6:0] lfsr = 7'h7F;
  task automatic prbs_drive();
    logic nb;
    nb = lfsr[6] ^ lfsr[5];
    lfsr = {lfsr[5:0], nb};
    equalizer_in = nb ? 1.0 : 0.0;
  endtask

  int busy_cnt, ready_in_train;

  initial begin
    tick(); tick();
    chk_r("reset_eq_analog", eq_analog, 0.0);
    chk_b("reset_out", equalizer_out, 1'b0);
    chk_b("reset_ready", coef_ready, 1'b1);
    chk_b("reset_busy", train_busy, 1'b0);
    chk_b("reset_done", train_done, 1'b0);
    reset = 1'b0;

    // Impulse response with default taps
    equalizer_in = 1.0; tick();
    equalizer_in = 0.0; tick();
    chk_r("imp0_analog", eq_analog, 2.003);
    chk_r("imp0_err", err, 1.003);
    chk_b("imp0_out", equalizer_out, 1'b1);
    tick();
    chk_r("imp1_analog", eq_analog, -0.9669);
    chk_b("imp1_out", equalizer_out, 1'b0);
    tick();
    chk_r("imp2_analog", eq_analog, -0.03657);
    chk_b("imp2_out", equalizer_out, 1'b0);

    // Strict threshold compare
    wr(0, 0, 0.49); wr(0, 1, 0.0); wr(0, 2, 0.0); wr(1, 0, 0.0); wr(1, 1, 0.0);
    equalizer_in = 1.0; tick(); tick();
    chk_r("thr_analog", eq_analog, 0.49);
    chk_b("thr_out", equalizer_out, 1'b0);
    wr(0, 0, 0.5); tick();
    chk_r("thr2_analog", eq_analog, 0.5);
    chk_b("thr2_out", equalizer_out, 1'b1);

    // Out-of-range index ignored, then saturated write
    wr(0, 5, 9.0); tick();
    chk_r("idx5_analog", eq_analog, 0.5);
    wr(1, 0, 10.0); tick();
    chk_r("sat_analog", eq_analog, 4.5);
    chk_r("sat_err", err, 3.5);

    // Restore defaults, then train on PRBS7 with a write coinciding with start
    wr(0, 0, 2.003); wr(0, 1, -1.409); wr(1, 0, 0.4421);
    busy_cnt = 0; ready_in_train = 0;
    prbs_drive();
    train_start = 1'b1; coef_wr = 1'b1; coef_fb = 1'b1; coef_idx = 3'd1; coef_data = 0.1;
    tick();
    train_start = 1'b0; coef_wr = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (train_busy) busy_cnt++;
      if (train_busy && coef_ready) ready_in_train++;
      prbs_drive();
      if (i == 3) begin
        coef_wr = 1'b1; coef_fb = 1'b0; coef_idx = 3'd0; coef_data = 3.0;
      end else begin
        coef_wr = 1'b0;
      end
      tick();
    end
    chk_i("train_busy_cycles", busy_cnt, TLEN);
    chk_i("train_ready_low", ready_in_train, 0);
    chk_b("train_done", train_done, 1'b1);

    // Retrain from HOLD with en low for 5 cycles mid-run
    busy_cnt = 0;
    train_start = 1'b1; tick(); train_start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (train_busy) busy_cnt++;
      en = (i >= 5 && i < 10) ? 1'b0 : 1'b1;
      prbs_drive();
      tick();
    end
    en = 1'b1;
    chk_i("freeze_busy_cycles", busy_cnt, TLEN + 5);
    chk_b("freeze_done", train_done, 1'b1);

    // Reset in the middle of training
    train_start = 1'b1; tick(); train_start = 1'b0;
    for (int i = 0; i < 4; i++) begin prbs_drive(); tick(); end
    chk_b("pre_reset_busy", train_busy, 1'b1);
    reset = 1'b1; tick(); reset = 1'b0;
    chk_b("mid_reset_busy", train_busy, 1'b0);
    chk_b("mid_reset_done", train_done, 1'b0);
    chk_r("mid_reset_analog", eq_analog, 0.0);
    chk_r("mid_reset_err", err, 0.0);
    chk_b("mid_reset_out", equalizer_out, 1'b0);
    equalizer_in = 1.0; tick();
    equalizer_in = 0.0; tick();
    chk_r("post_reset_imp0", eq_analog, 2.003);
    tick();
    chk_r("post_reset_imp1", eq_analog, -0.9669);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
